// File: rtl/fsm_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_mon_pkg
//  Description : Shared types and constants for the FSM deadlock monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package fsm_mon_pkg;

  // First-fault code reported on alarm_code.
  typedef enum logic [1:0] {
    CODE_NONE    = 2'd0,
    CODE_STUCK   = 2'd1,
    CODE_ILLEGAL = 2'd2
  } alarm_code_e;

  // Monitor control states.
  typedef enum logic [0:0] {
    WATCH   = 1'b0,
    RECOVER = 1'b1
  } ctrl_state_e;

  // Saturation ceilings of the dwell and recovery counters.
  localparam logic [15:0] DWELL_MAX = 16'hFFFF;
  localparam logic [7:0]  RCNT_MAX  = 8'hFF;

  // Increment that sticks at the all-ones ceiling.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DWELL_MAX) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_check.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_check
//  Description : Flags a vector whose population count is exactly one.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_check #(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] vec,
  output logic               is_onehot
);

  localparam int CNT_W = $clog2(STATE_W + 1);

  logic [CNT_W-1:0] cnt_w;

  // Population count of the observed vector.
  always_comb begin
    cnt_w = '0;
    for (int i = 0; i < STATE_W; i++) begin
      cnt_w = cnt_w + CNT_W'(vec[i]);
    end
  end

  assign is_onehot = (cnt_w == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/fsm_deadlock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_deadlock_monitor
//  Description : Watches a one-hot FSM state bus, flags illegal encodings and
//                states held too long, requests recovery and records the
//                first fault until software clears it.
//  Revision    : 1.0  initial release
// ============================================================================
module fsm_deadlock_monitor
  import fsm_mon_pkg::*;
#(
  parameter int                 STATE_W     = 4,
  parameter int                 TIMEOUT     = 16,
  parameter logic [STATE_W-1:0] EXEMPT_MASK = STATE_W'(1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STATE_W-1:0] mon_state,
  input  logic               mon_valid,
  input  logic               clr_alarm,
  input  logic               recover_ack,
  output logic               alarm,
  output logic [1:0]         alarm_code,
  output logic [STATE_W-1:0] stuck_state,
  output logic               recover_req,
  output logic [15:0]        dwell_count,
  output logic [7:0]         recover_count
);

  // Dwell value whose arrival marks a non-exempt state as stuck.
  localparam logic [15:0] DWELL_LIMIT = 16'(TIMEOUT - 1);

  ctrl_state_e        state_q, state_d;
  logic [STATE_W-1:0] ref_q, ref_d;
  logic               ref_vld_q, ref_vld_d;
  logic [15:0]        dwell_q, dwell_d;
  logic               alarm_q, alarm_d;
  alarm_code_e        code_q, code_d;
  logic [STATE_W-1:0] stuck_q, stuck_d;
  logic [7:0]         rcnt_q, rcnt_d;

  logic        is_onehot_w;
  logic        same_w;
  logic        exempt_w;
  logic [15:0] dwell_inc_w;
  logic        flt_illegal_w;
  logic        flt_stuck_w;

  onehot_check #(
    .STATE_W (STATE_W)
  ) u_onehot (
    .vec       (mon_state),
    .is_onehot (is_onehot_w)
  );

  assign same_w      = ref_vld_q && (mon_state == ref_q);
  assign exempt_w    = |(mon_state & EXEMPT_MASK);
  assign dwell_inc_w = sat_inc16(dwell_q);

  // Next-state: sample tracking, fault detection, first-fault capture, recovery.
  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    ref_vld_d     = ref_vld_q;
    dwell_d       = dwell_q;
    alarm_d       = alarm_q;
    code_d        = code_q;
    stuck_d       = stuck_q;
    rcnt_d        = rcnt_q;
    flt_illegal_w = 1'b0;
    flt_stuck_w   = 1'b0;
    case (state_q)
      WATCH: begin
        if (clr_alarm) begin
          alarm_d = 1'b0;
          code_d  = CODE_NONE;
          stuck_d = '0;
        end
        if (mon_valid) begin
          if (!is_onehot_w) begin
            // Illegal samples leave the reference and dwell untouched.
            flt_illegal_w = 1'b1;
          end else if (same_w) begin
            dwell_d     = dwell_inc_w;
            flt_stuck_w = !exempt_w && (dwell_inc_w == DWELL_LIMIT);
          end else begin
            ref_d     = mon_state;
            ref_vld_d = 1'b1;
            dwell_d   = '0;
          end
        end
        if (flt_illegal_w || flt_stuck_w) begin
          state_d = RECOVER;
          alarm_d = 1'b1;
          // A clear in the same cycle re-opens capture so the new fault wins.
          if ((code_q == CODE_NONE) || clr_alarm) begin
            code_d  = flt_illegal_w ? CODE_ILLEGAL : CODE_STUCK;
            stuck_d = mon_state;
          end
        end
      end
      RECOVER: begin
        if (recover_ack) begin
          state_d   = WATCH;
          ref_d     = '0;
          ref_vld_d = 1'b0;
          dwell_d   = '0;
          rcnt_d    = (rcnt_q == RCNT_MAX) ? rcnt_q : rcnt_q + 8'd1;
        end
      end
      default: state_d = WATCH;
    endcase
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WATCH;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      dwell_q   <= '0;
      alarm_q   <= 1'b0;
      code_q    <= CODE_NONE;
      stuck_q   <= '0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      dwell_q   <= dwell_d;
      alarm_q   <= alarm_d;
      code_q    <= code_d;
      stuck_q   <= stuck_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Request is a pure decode of the state so reset removes it immediately.
  assign recover_req   = (state_q == RECOVER);
  assign alarm         = alarm_q;
  assign alarm_code    = code_q;
  assign stuck_state   = stuck_q;
  assign dwell_count   = dwell_q;
  assign recover_count = rcnt_q;

endmodule
`default_nettype wire
